// File: rtl/trapez_peak_sampler.sv
// trapez_peak_sampler: baseline-tracking trigger that samples the trapezoid flat top and emits corrected energy
module trapez_peak_sampler #(
  parameter int SIZE_SHAPER_DATA = 16,
  parameter int SIZE_ENERGY = 16,
  parameter int SIZE_TIMESTAMP = 32,
  parameter int SAMPLE_DELAY = 40,
  parameter int HOLDOFF_TIME = 16,
  parameter int BASE_SHIFT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic signed [SIZE_SHAPER_DATA-1:0] shaper_data,
  input  logic signed [SIZE_SHAPER_DATA-1:0] threshold,
  input  logic enable,
  input  logic energy_ready,
  output logic energy_valid,
  output logic [SIZE_ENERGY-1:0] energy_data,
  output logic [SIZE_TIMESTAMP-1:0] energy_timestamp,
  output logic energy_pileup,
  output logic event_lost,
  output logic busy
);
  localparam int W = SIZE_SHAPER_DATA;
  localparam int E = SIZE_ENERGY;
  localparam int T = SIZE_TIMESTAMP;
  localparam int XW = (W + 1 > E + 1) ? W + 1 : E + 1;
  localparam int CMAX = (SAMPLE_DELAY > HOLDOFF_TIME) ? SAMPLE_DELAY : HOLDOFF_TIME;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic signed [XW-1:0] EMAX = XW'({E{1'b1}});
  typedef enum logic [1:0] {IDLE, DELAY, FALL, HOLDOFF} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [T-1:0] ts, trig_ts, pk_ts, en_ts;
  logic signed [W-1:0] baseline, peak;
  logic signed [W+1:0] level;
  logic signed [W:0] bdiff;
  logic signed [XW-1:0] ediff;
  logic [E-1:0] eclamp, en_d;
  logic gt, above, pileup, pk_v, pk_pile, en_v, en_pile;
  assign level = (W+2)'(baseline) + (W+2)'(threshold);
  assign gt = (W+2)'(shaper_data) > level;
  assign bdiff = (W+1)'(shaper_data) - (W+1)'(baseline);
  assign ediff = XW'(peak) - XW'(baseline);
  assign eclamp = ediff[XW-1] ? '0 : (ediff > EMAX) ? '1 : ediff[E-1:0];
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      ts <= '0;
      trig_ts <= '0;
      baseline <= '0;
      above <= 1'b0;
      pileup <= 1'b0;
      peak <= '0;
      pk_v <= 1'b0;
      pk_pile <= 1'b0;
      pk_ts <= '0;
    end else begin
      ts <= ts + 1'b1;
      pk_v <= 1'b0;
      case (state)
        IDLE: begin
          baseline <= baseline + W'(bdiff >>> BASE_SHIFT);
          if (enable && gt) begin
            state <= DELAY;
            trig_ts <= ts;
            cnt <= CW'(1);
            pileup <= 1'b0;
            above <= 1'b1;
          end
        end
        DELAY: begin
          above <= gt;
          if (gt && !above) pileup <= 1'b1;
          if (cnt == CW'(SAMPLE_DELAY)) begin
            state <= FALL;
            peak <= shaper_data;
            pk_v <= 1'b1;
            pk_pile <= pileup | (gt & ~above);
            pk_ts <= trig_ts;
          end else cnt <= cnt + 1'b1;
        end
        FALL: begin
          if (!gt) begin
            state <= HOLDOFF;
            cnt <= CW'(1);
          end
        end
        HOLDOFF: begin
          if (cnt == CW'(HOLDOFF_TIME)) state <= IDLE;
          else cnt <= cnt + 1'b1;
        end
      endcase
      // losing enable before the peak sample abandons the event silently
      if (state != IDLE && !enable) begin
        state <= IDLE;
        pk_v <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_v <= 1'b0;
      en_d <= '0;
      en_pile <= 1'b0;
      en_ts <= '0;
      energy_valid <= 1'b0;
      energy_data <= '0;
      energy_timestamp <= '0;
      energy_pileup <= 1'b0;
      event_lost <= 1'b0;
    end else begin
      en_v <= pk_v;
      en_d <= eclamp;
      en_pile <= pk_pile;
      en_ts <= pk_ts;
      event_lost <= 1'b0;
      if (en_v && (!energy_valid || energy_ready)) begin
        energy_valid <= 1'b1;
        energy_data <= en_d;
        energy_timestamp <= en_ts;
        energy_pileup <= en_pile;
      end else begin
        if (en_v) event_lost <= 1'b1;
        if (energy_ready) energy_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_trapez_peak_sampler.sv
// tb_trapez_peak_sampler: directed scenarios with hand-computed results and a small baseline model
module tb_trapez_peak_sampler;
  logic clk = 1'b0;
  logic reset;
  logic signed [15:0] shaper_data, threshold;
  logic enable, energy_ready;
  logic energy_valid;
  logic [15:0] energy_data;
  logic [31:0] energy_timestamp;
  logic energy_pileup, event_lost, busy;
  int n_tests = 0, n_fail = 0;
  int cyc, thr, m_b, m_idle, trig_cyc, nres, nlost, rise_cyc, lost_cyc;
  logic prev_valid, prev_busy, trig_busy, trig_prev_busy;
  logic [15:0] rise_data;
  logic [31:0] rise_ts;
  logic rise_pile;

  trapez_peak_sampler dut (
    .clk(clk), .reset(reset), .shaper_data(shaper_data), .threshold(threshold),
    .enable(enable), .energy_ready(energy_ready), .energy_valid(energy_valid),
    .energy_data(energy_data), .energy_timestamp(energy_timestamp),
    .energy_pileup(energy_pileup), .event_lost(event_lost), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int s);
    shaper_data = 16'(s);
    @(posedge clk);
    #1;
    if (m_idle != 0) begin
      if (enable && s > m_b + thr) begin
        m_idle = 0;
        trig_cyc = cyc;
        trig_busy = busy;
        trig_prev_busy = prev_busy;
      end
      m_b = m_b + ((s - m_b) >>> 4);
    end
    if (energy_valid && !prev_valid) begin
      nres++;
      rise_cyc = cyc;
      rise_data = energy_data;
      rise_ts = energy_timestamp;
      rise_pile = energy_pileup;
    end
    if (event_lost) begin
      nlost++;
      lost_cyc = cyc;
    end
    prev_valid = energy_valid;
    prev_busy = busy;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    shaper_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0; m_b = 0; m_idle = 1; trig_cyc = -1; nres = 0; nlost = 0;
    rise_cyc = -1; lost_cyc = -1; prev_valid = 1'b0; prev_busy = 1'b0;
    rise_data = '0; rise_ts = '0; rise_pile = 1'b0;
    trig_busy = 1'b0; trig_prev_busy = 1'b0;
  endtask

  task automatic pulse(input int base, input int amp, input int flat);
    for (int k = 0; k <= 32; k++) step(base + k * amp / 32);
    for (int k = 0; k < flat; k++) step(base + amp);
    for (int k = 31; k >= 0; k--) step(base + k * amp / 32);
  endtask

  task automatic test_reset();
    enable = 1'b0; energy_ready = 1'b1; thr = 100; threshold = 16'(thr);
    do_reset();
    n_tests++; if (energy_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", energy_valid); end
    n_tests++; if (energy_data !== 16'd0) begin n_fail++; $display("FAIL rst_data got %0d want 0", energy_data); end
    n_tests++; if (energy_timestamp !== 32'd0) begin n_fail++; $display("FAIL rst_ts got %0d want 0", energy_timestamp); end
    n_tests++; if (energy_pileup !== 1'b0) begin n_fail++; $display("FAIL rst_pileup got %b want 0", energy_pileup); end
    n_tests++; if (event_lost !== 1'b0) begin n_fail++; $display("FAIL rst_lost got %b want 0", event_lost); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    enable = 1'b1; energy_ready = 1'b1; thr = 100; threshold = 16'(thr);
    do_reset();
    repeat (5) step(0);
    pulse(0, 1000, 16);
    repeat (30) step(0);
    n_tests++; if (nres !== 1) begin n_fail++; $display("FAIL basic_count got %0d want 1", nres); end
    n_tests++; if (rise_data !== 16'd984) begin n_fail++; $display("FAIL basic_energy got %0d want 984", rise_data); end
    n_tests++; if (rise_ts !== 32'd9) begin n_fail++; $display("FAIL basic_ts got %0d want 9", rise_ts); end
    n_tests++; if (rise_pile !== 1'b0) begin n_fail++; $display("FAIL basic_pileup got %b want 0", rise_pile); end
    n_tests++; if (rise_cyc !== 51) begin n_fail++; $display("FAIL basic_latency got %0d want 51", rise_cyc); end
    n_tests++; if (trig_busy !== 1'b1 || trig_prev_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_rise got %b%b want 01", trig_prev_busy, trig_busy); end
    n_tests++; if (busy !== 1'b0 || energy_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_end got busy=%b valid=%b want 0 0", busy, energy_valid); end
  endtask

  task automatic test_baseline();
    int bl;
    enable = 1'b1; energy_ready = 1'b1; thr = 300; threshold = 16'(thr);
    do_reset();
    repeat (512) step(200);
    pulse(200, 1000, 32);
    repeat (40) step(200);
    bl = m_b;
    n_tests++; if (nres !== 1) begin n_fail++; $display("FAIL base_count got %0d want 1", nres); end
    n_tests++; if (rise_data !== 16'(1200 - bl)) begin n_fail++; $display("FAIL base_energy got %0d want %0d", rise_data, 1200 - bl); end
    n_tests++; if (rise_cyc !== trig_cyc + 42) begin n_fail++; $display("FAIL base_latency got %0d want %0d", rise_cyc, trig_cyc + 42); end
    n_tests++; if (rise_ts !== 32'(trig_cyc)) begin n_fail++; $display("FAIL base_ts got %0d want %0d", rise_ts, trig_cyc); end
  endtask

  task automatic test_pileup();
    enable = 1'b1; energy_ready = 1'b1; thr = 100; threshold = 16'(thr);
    do_reset();
    repeat (5) step(0);
    repeat (5) step(500);
    repeat (15) step(50);
    repeat (21) step(800);
    repeat (40) step(0);
    n_tests++; if (nres !== 1) begin n_fail++; $display("FAIL pile_count got %0d want 1", nres); end
    n_tests++; if (rise_pile !== 1'b1) begin n_fail++; $display("FAIL pile_flag got %b want 1", rise_pile); end
    n_tests++; if (rise_data !== 16'd769) begin n_fail++; $display("FAIL pile_energy got %0d want 769", rise_data); end
    n_tests++; if (rise_ts !== 32'd5) begin n_fail++; $display("FAIL pile_ts got %0d want 5", rise_ts); end
  endtask

  task automatic test_backpressure();
    enable = 1'b1; energy_ready = 1'b0; thr = 100; threshold = 16'(thr);
    do_reset();
    repeat (5) step(0);
    pulse(0, 1000, 16);
    repeat (60) step(0);
    pulse(0, 1000, 16);
    repeat (30) step(0);
    n_tests++; if (energy_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid got %b want 1", energy_valid); end
    n_tests++; if (energy_data !== 16'd984) begin n_fail++; $display("FAIL bp_held_data got %0d want 984", energy_data); end
    n_tests++; if (energy_timestamp !== 32'd9) begin n_fail++; $display("FAIL bp_held_ts got %0d want 9", energy_timestamp); end
    n_tests++; if (nlost !== 1) begin n_fail++; $display("FAIL bp_lost_count got %0d want 1", nlost); end
    n_tests++; if (lost_cyc !== 192) begin n_fail++; $display("FAIL bp_lost_cycle got %0d want 192", lost_cyc); end
    energy_ready = 1'b1;
    step(0);
    n_tests++; if (energy_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept got valid=%b want 0", energy_valid); end
  endtask

  task automatic test_clamp();
    enable = 1'b0; energy_ready = 1'b1; thr = -600; threshold = 16'(thr);
    do_reset();
    repeat (5) step(0);
    enable = 1'b1;
    repeat (46) step(-500);
    n_tests++; if (nres !== 1) begin n_fail++; $display("FAIL clamp_count got %0d want 1", nres); end
    n_tests++; if (rise_data !== 16'd0) begin n_fail++; $display("FAIL clamp_energy got %0d want 0", rise_data); end
    n_tests++; if (rise_ts !== 32'd5) begin n_fail++; $display("FAIL clamp_ts got %0d want 5", rise_ts); end
    n_tests++; if (rise_cyc !== 47) begin n_fail++; $display("FAIL clamp_latency got %0d want 47", rise_cyc); end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; energy_ready = 1'b0; thr = 100; threshold = 16'(thr);
    do_reset();
    repeat (5) step(0);
    pulse(0, 1000, 16);
    repeat (60) step(0);
    for (int k = 0; k <= 14; k++) step(k * 1000 / 32);
    n_tests++; if (energy_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre got valid=%b busy=%b want 1 1", energy_valid, busy); end
    reset = 1'b0;
    #1;
    n_tests++; if (energy_valid !== 1'b0 || energy_data !== 16'd0 || energy_timestamp !== 32'd0) begin n_fail++; $display("FAIL mid_clear got valid=%b data=%0d ts=%0d want 0 0 0", energy_valid, energy_data, energy_timestamp); end
    n_tests++; if (busy !== 1'b0 || event_lost !== 1'b0 || energy_pileup !== 1'b0) begin n_fail++; $display("FAIL mid_flags got busy=%b lost=%b pile=%b want 0 0 0", busy, event_lost, energy_pileup); end
    energy_ready = 1'b1;
    do_reset();
    repeat (5) step(0);
    pulse(0, 1000, 16);
    repeat (30) step(0);
    n_tests++; if (nres !== 1 || nlost !== 0) begin n_fail++; $display("FAIL mid_after_count got res=%0d lost=%0d want 1 0", nres, nlost); end
    n_tests++; if (rise_data !== 16'd984 || rise_ts !== 32'd9) begin n_fail++; $display("FAIL mid_after_result got %0d@%0d want 984@9", rise_data, rise_ts); end
  endtask

  initial begin
    reset = 1'b1; shaper_data = '0; threshold = '0; enable = 1'b0; energy_ready = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_baseline();
    test_pileup();
    test_backpressure();
    test_clamp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
